// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package nibble_serial_adder_pkg;

  // Width of the single carry-lookahead slice the datapath reuses every cycle.
  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice: y = a + b + cin, cout = carry out of bit 3.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    y    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single cla4 slice,
// with a carry flop chaining nibbles and a start/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / NibbleW;
  localparam int unsigned CntW    = $clog2(NIBBLES);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  // Bit offset of the current nibble (cnt * 4).
  logic [CntW+1:0]    bit_idx;
  logic [NibbleW-1:0] slice_y;
  logic               slice_cout;
  logic               last_nibble;

  assign bit_idx     = {cnt_q, 2'b00};
  assign last_nibble = (cnt_q == CntW'(NIBBLES - 1));

  cla4 u_cla4 (
    .a    (a_q[bit_idx +: NibbleW]),
    .b    (b_q[bit_idx +: NibbleW]),
    .cin  (carry_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // Next-state: accept in Idle/Done, one nibble per Busy cycle, publish at the last nibble.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        part_d[bit_idx +: NibbleW] = slice_y;
        carry_d                    = slice_cout;
        cnt_d                      = cnt_q + CntW'(1);
        if (last_nibble) begin
          // Outputs only move here, so no partial sum is ever visible.
          sum_d   = part_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any add in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) against an arithmetic reference.
module tb_nibble_serial_adder;

  localparam int unsigned W     = 16;
  localparam int unsigned NIBS  = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int unsigned  n_checks;
  int unsigned  n_fail;

  // Reference values of the most recently completed add (outputs must hold these).
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " sum"},  32'(sum),  32'd0);
    check({tag, " cout"}, 32'(cout), 32'd0);
    check({tag, " ovf"},  32'(overflow), 32'd0);
  endtask

  // Called at a negedge. Issues start, scrambles inputs while busy, checks the
  // busy window, the done pulse and the result. Returns at the negedge of the
  // done cycle with start low, so an immediate next call is back-to-back.
  task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input bit hold_start);
    logic [W:0]   full;
    logic [W-1:0] rs;
    logic         rov;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    rs   = full[W-1:0];
    rov  = (av[W-1] == bv[W-1]) && (rs[W-1] != av[W-1]);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = ci;
    @(posedge clk);
    for (int i = 0; i < int'(NIBS); i++) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " no done"}, 32'(done), 32'd0);
      check({tag, " hold sum"}, 32'(sum), 32'(exp_sum));
      // Anything on the inputs now must not disturb the add in flight.
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = hold_start ? 1'b1 : 1'($urandom);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(rs));
    check({tag, " cout"}, 32'(cout), 32'(full[W]));
    check({tag, " ovf"}, 32'(overflow), 32'(rov));
    exp_sum  = rs;
    exp_cout = full[W];
    exp_ovf  = rov;
    start    = 1'b0;
  endtask

  // Idle gap of n cycles starting from a done-cycle negedge with start low.
  task automatic idle_gap(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle done"}, 32'(done), 32'd0);
      check({tag, " idle sum"}, 32'(sum), 32'(exp_sum));
      check({tag, " idle cout"}, 32'(cout), 32'(exp_cout));
      check({tag, " idle ovf"}, 32'(overflow), 32'(exp_ovf));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    rst_n    = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_add("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
    idle_gap("zero", 2);
    run_add("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0);
    idle_gap("carry_chain", 1);
    run_add("wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
    idle_gap("ovf_neg", 1);

    // start held continuously across two adds.
    run_add("b2b_1", 16'd3, 16'd2, 1'b1, 1'b1);
    run_add("b2b_2", 16'd7, 16'd10, 1'b0, 1'b1);
    idle_gap("b2b", 1);

    // Reset during the second busy cycle.
    start = 1'b1;
    a     = 16'd15;
    b     = 16'd15;
    cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre_rst busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    for (int i = 0; i < int'(NIBS) + 2; i++) begin
      @(negedge clk);
      check("rst_held done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    idle_gap("post_rst", 2);
    run_add("post_rst", 16'd15, 16'd15, 1'b1, 1'b0);
    idle_gap("post_rst", 1);

    // Random vectors with a mix of back-to-back and gapped starts.
    for (int k = 0; k < 1000; k++) begin
      run_add("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) idle_gap("rand", int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
